kf8255_strobed_port: RTL and testbench

Per-port data and handshake stage of the KF8255 PPI that sits directly downstream of the group control registers. It consumes the group's mode select, port direction and mode-update strobe, and drives one 8-bit port in mode 0 (basic I/O) or mode 1 (strobed I/O with STB/IBF or OBF/ACK handshake and INTR). Port C handshake pins and CPU read data are produced here; bus decoding stays upstream.

---
 rtl/kf8255_strobed_port.sv | 151 +++++++++++++++
 tb/tb_kf8255_strobed_port.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf8255_strobed_port.sv
// Purpose: KF8255 per-port data path with mode 0 basic I/O and mode 1 STB/IBF, OBF/ACK handshake plus INTR.
// Latency: STB/ACK pin edge to flag update 3 falling edges; port_in to mode-0 read_data 2 edges; CPU strobes act on the sampling edge.
// Backpressure: none internally; the peripheral is paced by IBF/OBF and the CPU by INTR, strobes shorter than 3 clocks may be lost.
module kf8255_strobed_port (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic [1:0] i_mode_select_reg,
    input  logic       i_port_io_reg,
    input  logic       i_update_group_mode,
    input  logic [7:0] i_internal_data_bus,
    input  logic       i_write_port,
    input  logic       i_read_port,
    input  logic       i_write_inte,
    input  logic       i_inte_value,
    input  logic [7:0] i_port_in,
    input  logic       i_stb_n,
    input  logic       i_ack_n,
    output logic [7:0] o_port_out,
    output logic       o_port_oe,
    output logic [7:0] o_read_data,
    output logic       o_ibf,
    output logic       o_obf_n,
    output logic       o_intr
);

    // Synchronizer and edge-history flops for the asynchronous pins
    logic       r_stb_s1, r_stb_s2, r_stb_s3;
    logic       r_ack_s1, r_ack_s2, r_ack_s3;
    logic [7:0] r_pin_s1, r_pin_sync;

    // Handshake state and data latches
    logic [7:0] r_out_latch;
    logic [7:0] r_in_latch;
    logic       r_ibf;
    logic       r_obf_n;
    logic       r_intr_req;
    logic       r_inte;

    // Decoded edges and mode
    logic w_stb_fall, w_stb_rise;
    logic w_ack_fall, w_ack_rise;
    logic w_mode1, w_m1_in, w_m1_out;

    assign w_stb_fall = ~r_stb_s2 &  r_stb_s3;
    assign w_stb_rise =  r_stb_s2 & ~r_stb_s3;
    assign w_ack_fall = ~r_ack_s2 &  r_ack_s3;
    assign w_ack_rise =  r_ack_s2 & ~r_ack_s3;

    // Mode 1x is not supported by this port and falls back to basic I/O
    assign w_mode1  = (i_mode_select_reg == 2'b01);
    assign w_m1_in  = w_mode1 &  i_port_io_reg;
    assign w_m1_out = w_mode1 & ~i_port_io_reg;

    // Two-flop synchronizers; idle-high reset makes a strobe held low through reset look like a fresh edge
    always_ff @(negedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stb_s1   <= 1'b1;
            r_stb_s2   <= 1'b1;
            r_stb_s3   <= 1'b1;
            r_ack_s1   <= 1'b1;
            r_ack_s2   <= 1'b1;
            r_ack_s3   <= 1'b1;
            r_pin_s1   <= 8'h00;
            r_pin_sync <= 8'h00;
        end else begin
            r_stb_s1   <= i_stb_n;
            r_stb_s2   <= r_stb_s1;
            r_stb_s3   <= r_stb_s2;
            r_ack_s1   <= i_ack_n;
            r_ack_s2   <= r_ack_s1;
            r_ack_s3   <= r_ack_s2;
            r_pin_s1   <= i_port_in;
            r_pin_sync <= r_pin_s1;
        end
    end

    // Latches and handshake flags; a mode update overrides everything, and within a cycle set beats clear
    always_ff @(negedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_out_latch <= 8'h00;
            r_in_latch  <= 8'h00;
            r_ibf       <= 1'b0;
            r_obf_n     <= 1'b1;
            r_intr_req  <= 1'b0;
            r_inte      <= 1'b0;
        end else if (i_update_group_mode) begin
            r_out_latch <= 8'h00;
            r_in_latch  <= 8'h00;
            r_ibf       <= 1'b0;
            r_obf_n     <= 1'b1;
            r_intr_req  <= 1'b0;
            r_inte      <= 1'b0;
        end else begin
            if (i_write_inte) begin
                r_inte <= i_inte_value;
            end

            if (w_m1_in) begin
                if (w_stb_fall) begin
                    r_in_latch <= r_pin_sync;
                    r_ibf      <= 1'b1;
                end else if (i_read_port) begin
                    r_ibf      <= 1'b0;
                end
                // INTR is only raised by a strobe that actually filled the buffer
                if (w_stb_rise && r_ibf) begin
                    r_intr_req <= 1'b1;
                end else if (i_read_port) begin
                    r_intr_req <= 1'b0;
                end
            end else if (w_m1_out) begin
                // A fresh CPU write keeps the buffer full even if the peripheral acks in the same cycle
                if (i_write_port) begin
                    r_out_latch <= i_internal_data_bus;
                    r_obf_n     <= 1'b0;
                    r_intr_req  <= 1'b0;
                end else begin
                    if (w_ack_fall) begin
                        r_obf_n <= 1'b1;
                    end
                    if (w_ack_rise && r_obf_n) begin
                        r_intr_req <= 1'b1;
                    end
                end
            end else begin
                // Basic I/O: handshake flags parked inactive
                r_ibf      <= 1'b0;
                r_obf_n    <= 1'b1;
                r_intr_req <= 1'b0;
                if (i_write_port && !i_port_io_reg) begin
                    r_out_latch <= i_internal_data_bus;
                end
            end
        end
    end

    // CPU read mux: input ports return pins (mode 0) or the strobed latch (mode 1), output ports return the latch
    always_comb begin
        o_read_data = r_out_latch;
        if (i_port_io_reg) begin
            o_read_data = w_mode1 ? r_in_latch : r_pin_sync;
        end
    end

    assign o_port_out = r_out_latch;
    assign o_port_oe  = ~i_port_io_reg;
    assign o_ibf      = r_ibf;
    assign o_obf_n    = r_obf_n;
    assign o_intr     = r_intr_req & r_inte;

endmodule

// File: tb/tb_kf8255_strobed_port.sv
// Bench for kf8255_strobed_port: directed handshake scenarios, a behavioural model
// checked every cycle, and hand-computed literal expectations at key points.
module tb_kf8255_strobed_port;

    logic       clk;
    logic       reset_n;
    logic [1:0] mode;
    logic       io_reg;
    logic       upd;
    logic [7:0] data_bus;
    logic       write_port;
    logic       read_port;
    logic       write_inte;
    logic       inte_value;
    logic [7:0] port_in;
    logic       stb_n;
    logic       ack_n;
    logic [7:0] port_out;
    logic       port_oe;
    logic [7:0] read_data;
    logic       ibf;
    logic       obf_n;
    logic       intr;

    int n_checks = 0;
    int n_err    = 0;

    kf8255_strobed_port dut (
        .i_clock             (clk),
        .i_reset_n           (reset_n),
        .i_mode_select_reg   (mode),
        .i_port_io_reg       (io_reg),
        .i_update_group_mode (upd),
        .i_internal_data_bus (data_bus),
        .i_write_port        (write_port),
        .i_read_port         (read_port),
        .i_write_inte        (write_inte),
        .i_inte_value        (inte_value),
        .i_port_in           (port_in),
        .i_stb_n             (stb_n),
        .i_ack_n             (ack_n),
        .o_port_out          (port_out),
        .o_port_oe           (port_oe),
        .o_read_data         (read_data),
        .o_ibf               (ibf),
        .o_obf_n             (obf_n),
        .o_intr              (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pin histories: index 0 = value sampled on the previous falling edge, 1 = two edges ago, ...
    // The control logic acts on a pin level two edges old, compared with the level three edges old.
    logic       sh [3];
    logic       ah [3];
    logic [7:0] ph [2];
    logic [7:0] m_out, m_in;
    logic       m_ibf, m_obf_n, m_req, m_inte;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            sh[i] = 1'b1;
            ah[i] = 1'b1;
        end
        ph[0] = 8'h00; ph[1] = 8'h00;
        m_out = 8'h00; m_in = 8'h00;
        m_ibf = 1'b0; m_obf_n = 1'b1; m_req = 1'b0; m_inte = 1'b0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        logic s_fall, s_rise, a_fall, a_rise, m1;
        logic old_ibf, old_obf_n;
        logic [7:0] seen_pins;
        if (!reset_n) begin
            model_reset();
        end else begin
            s_fall    = !sh[1] &&  sh[2];
            s_rise    =  sh[1] && !sh[2];
            a_fall    = !ah[1] &&  ah[2];
            a_rise    =  ah[1] && !ah[2];
            seen_pins = ph[1];
            m1        = (mode == 2'b01);
            old_ibf   = m_ibf;
            old_obf_n = m_obf_n;
            if (upd) begin
                m_out = 8'h00; m_in = 8'h00;
                m_ibf = 1'b0; m_obf_n = 1'b1; m_req = 1'b0; m_inte = 1'b0;
            end else begin
                if (write_inte) m_inte = inte_value;
                if (m1 && io_reg) begin
                    m_req = (s_rise & old_ibf) | (m_req & ~read_port);
                    m_ibf = s_fall | (old_ibf & ~read_port);
                    if (s_fall) m_in = seen_pins;
                end else if (m1) begin
                    if (write_port) m_out = data_bus;
                    m_req   = ~write_port & (m_req | (a_rise & old_obf_n));
                    m_obf_n = ~write_port & (old_obf_n | a_fall);
                end else begin
                    m_ibf = 1'b0; m_obf_n = 1'b1; m_req = 1'b0;
                    if (write_port && !io_reg) m_out = data_bus;
                end
            end
            sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = stb_n;
            ah[2] = ah[1]; ah[1] = ah[0]; ah[0] = ack_n;
            ph[1] = ph[0]; ph[0] = port_in;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [7:0] exp_rd;
        #2;
        if (!io_reg)             exp_rd = m_out;
        else if (mode == 2'b01)  exp_rd = m_in;
        else                     exp_rd = ph[1];
        chk8("port_out",  port_out,  m_out);
        chk1("port_oe",   port_oe,   ~io_reg);
        chk8("read_data", read_data, exp_rd);
        chk1("ibf",       ibf,       m_ibf);
        chk1("obf_n",     obf_n,     m_obf_n);
        chk1("intr",      intr,      m_req & m_inte);
    end

    // ---------------- stimulus ----------------
    // Inputs change 3 time units after a falling edge; step() advances exactly one falling edge.
    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_mode(input logic [1:0] m, input logic io);
        mode = m; io_reg = io; upd = 1'b1;
        step();
        upd = 1'b0;
    endtask

    task automatic wr_inte(input logic v);
        write_inte = 1'b1; inte_value = v;
        step();
        write_inte = 1'b0;
    endtask

    task automatic wr_port(input logic [7:0] d);
        write_port = 1'b1; data_bus = d;
        step();
        write_port = 1'b0;
    endtask

    task automatic rd_port();
        read_port = 1'b1;
        step();
        read_port = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; mode = 2'b00; io_reg = 1'b1; upd = 1'b0;
        data_bus = 8'h00; write_port = 1'b0; read_port = 1'b0;
        write_inte = 1'b0; inte_value = 1'b0; port_in = 8'h00;
        stb_n = 1'b1; ack_n = 1'b1;
        steps(2);
        chk8("reset port_out",  port_out,  8'h00);
        chk8("reset read_data", read_data, 8'h00);
        chk1("reset ibf",       ibf,       1'b0);
        chk1("reset obf_n",     obf_n,     1'b1);
        chk1("reset intr",      intr,      1'b0);
        reset_n = 1'b1;
        step();

        // Mode 0 output
        set_mode(2'b00, 1'b0);
        write_port = 1'b1; data_bus = 8'hA5;
        step();
        write_port = 1'b0;
        chk8("m0 out port_out",  port_out,  8'hA5);
        chk1("m0 out port_oe",   port_oe,   1'b1);
        chk8("m0 out read_data", read_data, 8'hA5);
        chk1("m0 out ibf",   ibf,   1'b0);
        chk1("m0 out obf_n", obf_n, 1'b1);
        chk1("m0 out intr",  intr,  1'b0);

        // Mode 0 input: pins visible two edges later
        set_mode(2'b00, 1'b1);
        port_in = 8'h9E;
        step();
        step();
        chk8("m0 in read_data", read_data, 8'h9E);

        // Mode 1 input handshake
        set_mode(2'b01, 1'b1);
        wr_inte(1'b1);
        port_in = 8'h3C;
        steps(3);
        stb_n = 1'b0;
        steps(2);
        chk1("m1 in ibf edge2", ibf, 1'b0);
        step();
        chk1("m1 in ibf edge3", ibf, 1'b1);
        chk8("m1 in read_data", read_data, 8'h3C);
        step();
        stb_n = 1'b1;
        steps(2);
        chk1("m1 in intr edge2", intr, 1'b0);
        step();
        chk1("m1 in intr edge3", intr, 1'b1);
        rd_port();
        chk1("m1 in rd ibf",  ibf,  1'b0);
        chk1("m1 in rd intr", intr, 1'b0);

        // Mode 1 output handshake
        set_mode(2'b01, 1'b0);
        wr_inte(1'b1);
        wr_port(8'h5A);
        chk1("m1 out obf_n wr", obf_n, 1'b0);
        chk8("m1 out port_out", port_out, 8'h5A);
        ack_n = 1'b0;
        steps(2);
        chk1("m1 out obf_n edge2", obf_n, 1'b0);
        step();
        chk1("m1 out obf_n edge3", obf_n, 1'b1);
        step();
        ack_n = 1'b1;
        steps(2);
        chk1("m1 out intr edge2", intr, 1'b0);
        step();
        chk1("m1 out intr edge3", intr, 1'b1);
        wr_port(8'h77);
        chk1("m1 out wr2 intr",  intr,  1'b0);
        chk1("m1 out wr2 obf_n", obf_n, 1'b0);

        // INTE masks intr but not the request
        set_mode(2'b01, 1'b1);
        port_in = 8'hC3;
        steps(3);
        stb_n = 1'b0;
        steps(4);
        stb_n = 1'b1;
        steps(3);
        chk1("mask ibf",  ibf,  1'b1);
        chk1("mask intr", intr, 1'b0);
        chk8("mask read_data", read_data, 8'hC3);
        wr_inte(1'b1);
        chk1("unmask intr", intr, 1'b1);
        rd_port();

        // Collisions in mode 1 input: set wins over read_port
        port_in = 8'h81;
        steps(2);
        stb_n = 1'b0;
        steps(2);
        read_port = 1'b1;
        step();
        read_port = 1'b0;
        chk1("coll fall ibf", ibf, 1'b1);
        step();
        stb_n = 1'b1;
        steps(2);
        read_port = 1'b1;
        step();
        read_port = 1'b0;
        chk1("coll rise ibf",  ibf,  1'b0);
        chk1("coll rise intr", intr, 1'b1);
        rd_port();

        // Collisions in mode 1 output: CPU write wins over ack
        set_mode(2'b01, 1'b0);
        wr_inte(1'b1);
        wr_port(8'h11);
        ack_n = 1'b0;
        steps(2);
        write_port = 1'b1; data_bus = 8'h22;
        step();
        write_port = 1'b0;
        chk1("coll ack fall obf_n", obf_n, 1'b0);
        chk8("coll ack fall port_out", port_out, 8'h22);
        step();
        ack_n = 1'b1;
        steps(3);
        chk1("no intr while full", intr, 1'b0);
        ack_n = 1'b0;
        steps(3);
        chk1("second ack obf_n", obf_n, 1'b1);
        step();
        ack_n = 1'b1;
        steps(2);
        write_port = 1'b1; data_bus = 8'h33;
        step();
        write_port = 1'b0;
        chk1("coll ack rise intr",  intr,  1'b0);
        chk1("coll ack rise obf_n", obf_n, 1'b0);

        // Mode update clears everything on its edge
        set_mode(2'b01, 1'b1);
        wr_inte(1'b1);
        port_in = 8'h5F;
        steps(3);
        stb_n = 1'b0;
        steps(4);
        stb_n = 1'b1;
        steps(3);
        chk1("pre upd ibf",  ibf,  1'b1);
        chk1("pre upd intr", intr, 1'b1);
        upd = 1'b1;
        step();
        upd = 1'b0;
        chk1("upd ibf",   ibf,   1'b0);
        chk1("upd intr",  intr,  1'b0);
        chk1("upd obf_n", obf_n, 1'b1);
        chk8("upd read_data", read_data, 8'h00);
        chk8("upd port_out",  port_out,  8'h00);

        // Reset mid-handshake, strobe still low afterwards
        stb_n = 1'b0;
        steps(3);
        chk1("pre rst ibf", ibf, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("async rst ibf", ibf, 1'b0);
        chk8("async rst read_data", read_data, 8'h00);
        chk8("async rst port_out",  port_out,  8'h00);
        chk1("async rst obf_n", obf_n, 1'b1);
        steps(2);
        reset_n = 1'b1;
        steps(2);
        chk1("post rst ibf edge2", ibf, 1'b0);
        step();
        chk1("post rst ibf edge3", ibf, 1'b1);
        chk8("post rst read_data", read_data, 8'h5F);
        stb_n = 1'b1;
        steps(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
